// File: rtl/ball_loop_prog_if.sv
// Launch/operand/status bundle for ball_loop_prog. The master drives start and the
// operands; the slave (the program circuit) drives location and status.
interface ball_loop_prog_if #(
  parameter int W  = 8,
  parameter int CW = 3
);
  logic          start;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic [W-1:0]  b_in;
  logic [8:0]    loc;
  logic          busy;
  logic          done;
  logic          err;
  logic          prop;
  logic [CW-1:0] iter;
  logic [W-1:0]  z_out;

  modport master (
    output start, x_in, y_in, b_in,
    input  loc, busy, done, err, prop, iter, z_out
  );

  modport slave (
    input  start, x_in, y_in, b_in,
    output loc, busy, done, err, prop, iter, z_out
  );
endinterface

// File: rtl/ball_loop_prog.sv
// One-hot location machine running a bounded while-loop over W-bit operands; err marks
// a reachable safety violation (only possible when BUG_MODE selects the weak check).
module ball_loop_prog #(
  parameter int W        = 8,
  parameter int MAX_ITER = 4,
  parameter int STEP     = 1,
  parameter int BUG_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  ball_loop_prog_if.slave io_bus
);
  localparam int            CW     = $clog2(MAX_ITER + 1);
  localparam logic [W-1:0]  STEP_W = W'(STEP);
  localparam logic [CW-1:0] MAX_W  = CW'(MAX_ITER);

  typedef enum logic [8:0] {
    S_IDLE   = 9'h001,
    S_CMP_XY = 9'h002,
    S_INIT   = 9'h004,
    S_CMP_AB = 9'h008,
    S_UPD    = 9'h010,
    S_WAIT   = 9'h020,
    S_CHECK  = 9'h040,
    S_DONE   = 9'h080,
    S_ERR    = 9'h100
  } loc_e;

  loc_e          r_loc,  w_loc_nxt;
  logic [W-1:0]  r_x,    w_x_nxt;
  logic [W-1:0]  r_y,    w_y_nxt;
  logic [W-1:0]  r_a,    w_a_nxt;
  logic [W-1:0]  r_b,    w_b_nxt;
  logic [W-1:0]  r_z,    w_z_nxt;
  logic [CW-1:0] r_iter, w_iter_nxt;
  logic          r_t1,   w_t1_nxt;
  logic          r_onehot_ok;
  logic          w_check;

  // State register. A corrupted (non one-hot) location freezes everything but the
  // health flag, so the fault stays visible instead of wandering through the graph.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loc       <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_t1        <= 1'b0;
      r_onehot_ok <= 1'b1;
    end else begin
      r_onehot_ok <= $onehot(r_loc);
      if (r_onehot_ok) begin
        r_loc  <= w_loc_nxt;
        r_x    <= w_x_nxt;
        r_y    <= w_y_nxt;
        r_a    <= w_a_nxt;
        r_b    <= w_b_nxt;
        r_z    <= w_z_nxt;
        r_iter <= w_iter_nxt;
        r_t1   <= w_t1_nxt;
      end
    end
  end

  assign w_check = (BUG_MODE != 0) ? (r_x < r_a) : (r_x < r_z);

  always_comb begin
    // NOTE: every combinational output gets a hold default first, so no path through
    // the case can leave a variable unassigned and infer a latch.
    w_loc_nxt  = r_loc;
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_a_nxt    = r_a;
    w_b_nxt    = r_b;
    w_z_nxt    = r_z;
    w_iter_nxt = r_iter;
    w_t1_nxt   = r_t1;
    case (r_loc)
      S_IDLE, S_DONE: begin
        if (io_bus.start) begin
          w_loc_nxt = S_CMP_XY;
          w_x_nxt   = io_bus.x_in;
          w_y_nxt   = io_bus.y_in;
          w_b_nxt   = io_bus.b_in;
        end
      end
      S_CMP_XY: w_loc_nxt = (r_x < r_y) ? S_INIT : S_DONE;
      S_INIT: begin
        w_a_nxt    = r_y;
        w_iter_nxt = '0;
        w_t1_nxt   = 1'b0;
        w_loc_nxt  = S_CMP_AB;
      end
      S_CMP_AB: begin
        if (r_a < r_b)  w_loc_nxt = S_UPD;
        else if (r_t1)  w_loc_nxt = S_CHECK;
        else            w_loc_nxt = S_DONE;
      end
      S_UPD: begin
        w_z_nxt    = r_b;
        w_t1_nxt   = 1'b1;
        w_a_nxt    = r_a + STEP_W;
        w_iter_nxt = r_iter + CW'(1);
        w_loc_nxt  = S_WAIT;
      end
      S_WAIT:  w_loc_nxt = (r_iter == MAX_W) ? S_CHECK : S_CMP_AB;
      S_CHECK: w_loc_nxt = w_check ? S_DONE : S_ERR;
      S_ERR:   w_loc_nxt = S_ERR;
      default: w_loc_nxt = r_loc;
    endcase
  end

  always_comb begin
    io_bus.loc   = r_loc;
    io_bus.busy  = !(r_loc inside {S_IDLE, S_DONE, S_ERR});
    io_bus.done  = (r_loc == S_DONE);
    io_bus.err   = (r_loc == S_ERR);
    io_bus.prop  = (r_loc != S_ERR);
    io_bus.iter  = r_iter;
    io_bus.z_out = r_z;
  end
endmodule
